screen_rom_ctrl: RTL and testbench
==================================

Name: screen_rom_ctrl

Overview:
- Sequences reads from the 471x250 title-screen ROM (8-bit pixels, 17-bit address, 1-clock registered read) for the VGA pixel pipeline.
- Maps incoming pixel coordinates to ROM addresses using an incremental counter, with no multiplier.
- Realigns the returned ROM data with its pixel. Substitutes a background colour outside the image window.
- Enables and disables the screen only on frame boundaries, so frames never tear.

Parameters:
- IMG_W, 471, image width in pixels
- IMG_H, 250, image height in lines
- X0, 84, left column of the image window
- Y0, 115, top line of the image window
- BG_COLOR, 8'h00, pixel value driven outside the window or when inactive
- ROM_LAT, 1, ROM read latency in clocks; legal range 1..3

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_pix_tick  in  1  pixel strobe; one clock pulse per displayed pixel
- i_x  in  10  current pixel column, valid when i_pix_tick=1
- i_y  in  10  current pixel line, valid when i_pix_tick=1
- i_video_on  in  1  pixel lies in the visible area
- i_frame_start  in  1  one-clock pulse before pixel (0,0) of each frame
- i_enable  in  1  level request to show the screen
- o_rom_addr  out  17  address to the ROM
- i_rom_data  in  8  ROM output, valid ROM_LAT clocks after o_rom_addr
- o_pixel  out  8  output pixel value
- o_pixel_valid  out  1  o_pixel corresponds to a tick (pulse)
- o_active  out  1  screen currently being displayed
- o_busy  out  1  state is not IDLE

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE; addr counter=0.
  - o_rom_addr=0, o_pixel=BG_COLOR, o_pixel_valid=0, o_active=0, o_busy=0.
  - Pipeline valid bits cleared.
  - Reset during any state returns to IDLE immediately; no partial-frame output afterwards.
- FSM states and transitions:
  - IDLE -> ARM when i_enable=1.
  - ARM -> ACTIVE on i_frame_start. If i_enable drops while in ARM, return to IDLE.
  - ACTIVE -> DRAIN when i_enable=0; the current frame completes.
  - DRAIN -> IDLE on the next i_frame_start. If i_enable rises again while in DRAIN, return to ACTIVE with no frame gap.
  - i_enable rising on the same clock as i_frame_start while in IDLE gives ARM only; ACTIVE starts at the following frame.
- o_active=1 in ACTIVE and DRAIN. o_busy=1 in ARM, ACTIVE and DRAIN.
- In-window test: i_video_on && X0<=i_x<X0+IMG_W && Y0<=i_y<Y0+IMG_H, using unsigned 10-bit compares.
- Address generation:
  - Counter clears to 0 on every i_frame_start.
  - On each i_pix_tick in-window while o_active: o_rom_addr <= counter (registered, clock T+1), then counter += 1.
  - Counter saturates at IMG_W*IMG_H-1 (117749) and never wraps.
  - o_rom_addr holds its value when there is no in-window tick.
- Output pipeline:
  - The tick at clock T yields o_pixel_valid=1 at T+2+ROM_LAT, which is T+3 at the default. o_pixel_valid pulses once per tick.
  - o_pixel = i_rom_data if the tick was in-window and o_active at tick time; otherwise BG_COLOR.
  - A delay line of depth 1+ROM_LAT carries the valid and in-window flags.
  - Back-to-back ticks (every clock) are supported without stalls.
- A state change mid-pipeline does not alter pixels already issued; each pixel uses the flags captured at its tick.
- o_pixel holds its last value when o_pixel_valid=0.

Optional Feature:
- Macro: SCREEN_BORDER_EN.
- When defined: ticks on the 1-pixel ring just outside the window output 8'hFF while o_active. The ring is x=X0-1 or x=X0+IMG_W on lines Y0-1..Y0+IMG_H, and y=Y0-1 or y=Y0+IMG_H on columns X0-1..X0+IMG_W. No ROM read is issued for ring pixels, and latency is unchanged.
- When undefined: ring pixels output BG_COLOR. No border logic is present.

Test Plan:
- Reset with i_enable=1 held, release, pulse i_frame_start -> ARM, then ACTIVE at the 2nd frame_start; all outputs at reset values while i_rst_n=0.
- ACTIVE full frame, tick every clock -> first in-window tick at (84,115) gives o_rom_addr=0. (554,115) gives 470. (84,116) gives 471. (554,364) gives 117749. Exactly 117750 ROM-sourced pixels per frame.
- Tick at (83,115) and (555,364) -> o_pixel=BG_COLOR exactly 3 clocks after tick (ROM_LAT=1); model ROM returns addr[7:0], checked against o_pixel.
- Drop i_enable mid-frame at line 200 -> remaining window pixels still from ROM (DRAIN). Next frame_start gives IDLE; the following frame is all BG_COLOR.
- Assert i_rst_n=0 mid-frame at addr 5000 -> outputs return to reset values at once. Re-enable -> next displayed frame starts at addr 0.
- SCREEN_BORDER_EN defined: tick (83,200) -> o_pixel=8'hFF; (82,200) -> BG_COLOR; no o_rom_addr change on either.

Source files
------------

// File: rtl/screen_rom_ctrl.sv
// Title-screen ROM read sequencer: maps pixel ticks to ROM addresses and realigns ROM data.
// Optional 1-pixel 8'hFF frame around the image: define SCREEN_BORDER_EN.
module screen_rom_ctrl #(
  parameter int          IMG_W    = 471,
  parameter int          IMG_H    = 250,
  parameter int          X0       = 84,
  parameter int          Y0       = 115,
  parameter logic [7:0]  BG_COLOR = 8'h00,
  parameter int          ROM_LAT  = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_pix_tick,
  input  logic [9:0]  i_x,
  input  logic [9:0]  i_y,
  input  logic        i_video_on,
  input  logic        i_frame_start,
  input  logic        i_enable,
  output logic [16:0] o_rom_addr,
  input  logic [7:0]  i_rom_data,
  output logic [7:0]  o_pixel,
  output logic        o_pixel_valid,
  output logic        o_active,
  output logic        o_busy
);

  localparam logic [9:0]  X_LO     = 10'(X0);
  localparam logic [9:0]  X_HI     = 10'(X0 + IMG_W);
  localparam logic [9:0]  Y_LO     = 10'(Y0);
  localparam logic [9:0]  Y_HI     = 10'(Y0 + IMG_H);
  localparam logic [16:0] ADDR_MAX = 17'(IMG_W * IMG_H - 1);

  typedef enum logic [1:0] {IDLE, ARM, ACTIVE, DRAIN} state_e;
  state_e state_q, state_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Enable changes take effect only at frame boundaries, except leaving ARM/entering ACTIVE from DRAIN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (i_enable) state_d = ARM;
      ARM:    if (!i_enable) state_d = IDLE;
              else if (i_frame_start) state_d = ACTIVE;
      ACTIVE: if (!i_enable) state_d = DRAIN;
      DRAIN:  if (i_enable) state_d = ACTIVE;
              else if (i_frame_start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign o_active = (state_q == ACTIVE) || (state_q == DRAIN);
  assign o_busy   = (state_q != IDLE);

  logic in_win, rom_tick;
  assign in_win = i_video_on && (i_x >= X_LO) && (i_x < X_HI) &&
                  (i_y >= Y_LO) && (i_y < Y_HI);
  assign rom_tick = i_pix_tick && in_win && o_active;

  // Raster order inside the window makes the address a running count of window ticks.
  logic [16:0] cnt_q, cnt_d, addr_q, addr_d;
  always_comb begin
    cnt_d  = cnt_q;
    addr_d = addr_q;
    if (rom_tick) begin
      addr_d = cnt_q;
      if (cnt_q != ADDR_MAX) cnt_d = cnt_q + 17'd1;
    end
    if (i_frame_start) cnt_d = '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q  <= '0;
      addr_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
    end
  end

  assign o_rom_addr = addr_q;

  // Flags ride alongside the ROM read so the last stage lines up with i_rom_data.
  logic [ROM_LAT:0] vld_q, rom_q;
  logic [7:0]       pix_q;
  logic             pv_q;

`ifdef SCREEN_BORDER_EN
  localparam logic [9:0] X_RL = 10'(X0 - 1);
  localparam logic [9:0] Y_RL = 10'(Y0 - 1);
  logic             on_ring, brd_tick;
  logic [ROM_LAT:0] brd_q;
  assign on_ring = i_video_on &&
    ((((i_x == X_RL) || (i_x == X_HI)) && (i_y >= Y_RL) && (i_y <= Y_HI)) ||
     (((i_y == Y_RL) || (i_y == Y_HI)) && (i_x >= X_RL) && (i_x <= X_HI)));
  assign brd_tick = i_pix_tick && on_ring && o_active;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) brd_q <= '0;
    else          brd_q <= {brd_q[ROM_LAT-1:0], brd_tick};
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_q <= '0;
      rom_q <= '0;
      pv_q  <= 1'b0;
      pix_q <= BG_COLOR;
    end else begin
      vld_q <= {vld_q[ROM_LAT-1:0], i_pix_tick};
      rom_q <= {rom_q[ROM_LAT-1:0], rom_tick};
      pv_q  <= vld_q[ROM_LAT];
      if (vld_q[ROM_LAT]) begin
        if (rom_q[ROM_LAT]) pix_q <= i_rom_data;
`ifdef SCREEN_BORDER_EN
        else if (brd_q[ROM_LAT]) pix_q <= 8'hFF;
`endif
        else pix_q <= BG_COLOR;
      end
    end
  end

  assign o_pixel       = pix_q;
  assign o_pixel_valid = pv_q;

endmodule

// File: tb/tb_screen_rom_ctrl.sv
// Randomised and directed bench for screen_rom_ctrl against a coordinate-level reference model.
module tb_screen_rom_ctrl;
  localparam logic [7:0] BG = 8'h00;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       pix_tick = 1'b0, video_on = 1'b0, frame_start = 1'b0, enable = 1'b0;
  logic [9:0] x_in = '0, y_in = '0;
  logic [16:0] addr0, addr1;
  logic [7:0]  rom0 = '0, rom1 = '0, pix0, pix1;
  logic        pv0, pv1, act0, act1, busy0, busy1;

  always #5 clk = ~clk;

  // ROM models: one-clock registered read returning the low address byte.
  always @(posedge clk) begin
    rom0 <= addr0[7:0];
    rom1 <= addr1[7:0];
  end

  screen_rom_ctrl u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_tick(pix_tick), .i_x(x_in), .i_y(y_in),
    .i_video_on(video_on), .i_frame_start(frame_start), .i_enable(enable),
    .o_rom_addr(addr0), .i_rom_data(rom0), .o_pixel(pix0), .o_pixel_valid(pv0),
    .o_active(act0), .o_busy(busy0)
  );

  // Small image so counter saturation is reachable in a short run.
  screen_rom_ctrl #(.IMG_W(6), .IMG_H(3), .X0(2), .Y0(1)) u_small (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_tick(pix_tick), .i_x(x_in), .i_y(y_in),
    .i_video_on(video_on), .i_frame_start(frame_start), .i_enable(enable),
    .o_rom_addr(addr1), .i_rom_data(rom1), .o_pixel(pix1), .o_pixel_valid(pv1),
    .o_active(act1), .o_busy(busy1)
  );

  int checks = 0, errors = 0, cyc = 0;
  int mst = 0;            // 0 idle, 1 armed, 2 showing, 3 finishing frame
  int cnt[2], eaddr[2];
  logic [7:0] lp[2];
  logic [7:0] exp_q0[$], exp_q1[$];
  int due_q0[$], due_q1[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int geo(input int k, input int sel);
    int g[4];
    if (k == 0) g = '{84, 115, 471, 250};
    else        g = '{2, 1, 6, 3};
    return g[sel];
  endfunction

  function automatic bit in_win(input int k, input int x, input int y, input bit von);
    int x0, y0, w, h;
    x0 = geo(k, 0); y0 = geo(k, 1); w = geo(k, 2); h = geo(k, 3);
    return von && x >= x0 && x < x0 + w && y >= y0 && y < y0 + h;
  endfunction

  function automatic bit on_ring(input int k, input int x, input int y, input bit von);
    int x0, y0, w, h;
    x0 = geo(k, 0); y0 = geo(k, 1); w = geo(k, 2); h = geo(k, 3);
    return von && ((((x == x0 - 1) || (x == x0 + w)) && y >= y0 - 1 && y <= y0 + h) ||
                   (((y == y0 - 1) || (y == y0 + h)) && x >= x0 - 1 && x <= x0 + w));
  endfunction

  task automatic cmp(input int k, input logic [16:0] a, input logic [7:0] p,
                     input logic v, input logic ac, input logic bz);
    bit ev;
    logic [7:0] ep;
    ev = 1'b0;
    ep = lp[k];
    if (k == 0) begin
      if (due_q0.size() != 0 && due_q0[0] == cyc) begin
        ev = 1'b1; ep = exp_q0.pop_front(); void'(due_q0.pop_front());
      end
    end else begin
      if (due_q1.size() != 0 && due_q1[0] == cyc) begin
        ev = 1'b1; ep = exp_q1.pop_front(); void'(due_q1.pop_front());
      end
    end
    lp[k] = ep;
    check($sformatf("valid%0d", k), int'(v), int'(ev));
    check($sformatf("pixel%0d", k), int'(p), int'(ep));
    check($sformatf("addr%0d", k), int'(a), eaddr[k]);
    check($sformatf("active%0d", k), int'(ac), int'(mst >= 2));
    check($sformatf("busy%0d", k), int'(bz), int'(mst != 0));
  endtask

  // Inputs settle 1 time unit after each rising edge, so the falling edge sees both
  // the outputs of the last edge and the inputs of the next one.
  always @(negedge clk) begin
    bit act, iw;
    logic [7:0] ep;
    cyc++;
    if (!rst_n) begin
      mst = 0;
      for (int k = 0; k < 2; k++) begin cnt[k] = 0; eaddr[k] = 0; lp[k] = BG; end
      exp_q0.delete(); exp_q1.delete(); due_q0.delete(); due_q1.delete();
    end
    cmp(0, addr0, pix0, pv0, act0, busy0);
    cmp(1, addr1, pix1, pv1, act1, busy1);
    if (rst_n) begin
      act = (mst >= 2);
      for (int k = 0; k < 2; k++) begin
        if (pix_tick) begin
          iw = in_win(k, int'(x_in), int'(y_in), video_on);
          ep = BG;
          if (iw && act) begin
            eaddr[k] = cnt[k];
            ep = 8'(cnt[k]);
            if (cnt[k] < geo(k, 2) * geo(k, 3) - 1) cnt[k]++;
          end
`ifdef SCREEN_BORDER_EN
          else if (act && on_ring(k, int'(x_in), int'(y_in), video_on)) ep = 8'hFF;
`endif
          if (k == 0) begin exp_q0.push_back(ep); due_q0.push_back(cyc + 3); end
          else        begin exp_q1.push_back(ep); due_q1.push_back(cyc + 3); end
        end
        if (frame_start) cnt[k] = 0;
      end
      case (mst)
        0: if (enable) mst = 1;
        1: if (!enable) mst = 0; else if (frame_start) mst = 2;
        2: if (!enable) mst = 3;
        3: if (enable) mst = 2; else if (frame_start) mst = 0;
        default: mst = 0;
      endcase
    end
  end

  task automatic drive(input bit tk, input int x, input int y, input bit von, input bit fs);
    pix_tick = tk; x_in = 10'(x); y_in = 10'(y); video_on = von; frame_start = fs;
    @(posedge clk); #1;
    pix_tick = 1'b0; frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 1, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"}, int'(addr0), 0);
    check({tag, "_pixel"}, int'(pix0), int'(BG));
    check({tag, "_valid"}, int'(pv0), 0);
    check({tag, "_active"}, int'(act0), 0);
    check({tag, "_busy"}, int'(busy0), 0);
  endtask

  initial begin
    logic [16:0] held;
    int sel, r;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // frame_start on the same clock that IDLE sees enable only arms
    drive(0, 0, 0, 1, 1);
    check("armed_busy", int'(busy0), 1);
    check("armed_active", int'(act0), 0);
    idle(5);
    drive(0, 0, 0, 1, 1);
    check("second_fs_active", int'(act0), 1);

    // Full-width sweep over the top window rows, one tick per clock
    for (int y = 114; y <= 117; y++)
      for (int x = 80; x <= 560; x++) begin
        drive(1, x, y, 1, 0);
        if (x == 84 && y == 115)  check("addr_first", int'(addr0), 0);
        if (x == 554 && y == 115) check("addr_row_end", int'(addr0), 470);
        if (x == 84 && y == 116)  check("addr_row2", int'(addr0), 471);
        if (x == 554 && y == 116) check("addr_row2_end", int'(addr0), 941);
      end
    idle(4);

    // Two passes over the small window in one frame drive its counter into saturation
    drive(0, 0, 0, 1, 1);
    for (int p = 0; p < 2; p++)
      for (int y = 0; y <= 5; y++)
        for (int x = 0; x <= 9; x++) drive(1, x, y, 1, 0);
    check("small_saturate", int'(addr1), 17);
    idle(4);

`ifdef SCREEN_BORDER_EN
    held = addr0;
    drive(1, 83, 200, 1, 0);
    idle(2);
    check("ring_pixel", int'(pix0), 8'hFF);
    check("ring_no_read", int'(addr0), int'(held));
    drive(1, 82, 200, 1, 0);
    idle(2);
    check("outside_ring_pixel", int'(pix0), int'(BG));
    check("outside_no_read", int'(addr0), int'(held));
`endif

    // Disable mid-frame: the rest of the frame still reads the ROM, the next one is blank
    drive(0, 0, 0, 1, 1);
    for (int x = 84; x <= 120; x++) drive(1, x, 115, 1, 0);
    enable = 1'b0;
    for (int x = 80; x <= 120; x++) drive(1, x, 200, 1, 0);
    check("drain_active", int'(act0), 1);
    check("drain_busy", int'(busy0), 1);
    drive(0, 0, 0, 1, 1);
    check("drain_to_idle", int'(busy0), 0);
    drive(0, 0, 0, 1, 1);
    for (int x = 80; x <= 120; x++) drive(1, x, 115, 1, 0);
    idle(4);
    check("idle_frame_pixel", int'(pix0), int'(BG));

    // Reset in the middle of a frame once the address has reached 5000
    enable = 1'b1;
    idle(1);
    drive(0, 0, 0, 1, 1);
    for (int n = 0; n <= 5000; n++) drive(1, 84 + n % 471, 115 + n / 471, 1, 0);
    check("addr_5000", int'(addr0), 5000);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    drive(0, 0, 0, 1, 1);
    drive(1, 84, 115, 1, 0);
    check("restart_addr0", int'(addr0), 0);
    drive(1, 85, 115, 1, 0);
    check("restart_addr1", int'(addr0), 1);

    // Random ticks near window corners and the small window, with random enable/frame events
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) enable = ~enable;
      if (r >= 2 && r < 4) drive(0, 0, 0, 1, 1);
      else begin
        sel = $urandom_range(0, 2);
        if (sel == 0)      drive($urandom_range(0, 3) != 0, $urandom_range(80, 90),
                                 $urandom_range(112, 120), $urandom_range(0, 9) != 0, 0);
        else if (sel == 1) drive($urandom_range(0, 3) != 0, $urandom_range(548, 560),
                                 $urandom_range(360, 368), $urandom_range(0, 9) != 0, 0);
        else               drive($urandom_range(0, 3) != 0, $urandom_range(0, 9),
                                 $urandom_range(0, 5), $urandom_range(0, 9) != 0, 0);
      end
    end
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
